// File: rtl/instr_decode_queue_if.sv
// instr_decode_queue_if
//   Bundles the fetch-side and execute-side handshakes of instr_decode_queue.
//   slave  : view taken by the queue itself
//   master : view taken by the surrounding pipeline / testbench
// Signals
//   in_valid/in_ready/in_instr/in_pc  : raw instruction offered by fetch
//   out_valid/out_ready               : head-of-queue handshake to execute
//   out_op/out_fmt/out_rd/out_cond/out_rs1/out_rs2/out_funct3 : decoded fields
//   out_imm/out_pc/out_illegal        : immediate, PC and illegal flag of head
//   count                             : current occupancy
interface instr_decode_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_op;
    logic [2:0]      out_fmt;
    logic [4:0]      out_rd;
    logic [4:0]      out_cond;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;
    logic [CW-1:0]   count;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_op, out_fmt, out_rd, out_cond, out_rs1, out_rs2,
               out_funct3, out_imm, out_pc, out_illegal, count
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_op, out_fmt, out_rd, out_cond, out_rs1, out_rs2,
               out_funct3, out_imm, out_pc, out_illegal, count
    );
endinterface

// File: rtl/instr_decode_queue.sv
// instr_decode_queue
//   Decode-and-buffer stage between fetch and execute. Each raw word is decoded
//   as it is enqueued (format, raw register fields, sign-extended immediate,
//   illegal flag) and the decoded entry is stored in a DEPTH-entry FIFO that is
//   presented in order on the out_* handshake.
// Ports
//   i_clk    : clock, all state on rising edge
//   i_rst    : synchronous active-high reset (priority over flush)
//   i_flush  : synchronous discard of every queued entry
//   io_bus   : instr_decode_queue_if.slave (see interface header)
module instr_decode_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    instr_decode_queue_if.slave  io_bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] FmtR    = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtU    = 3'd3;
    localparam logic [2:0] FmtCi   = 3'd4;
    localparam logic [2:0] FmtCu   = 3'd5;
    localparam logic [2:0] FmtNone = 3'd6;
    localparam logic [2:0] FmtIll  = 3'd7;

    // Only instr[24:0] is needed after decode: opcode, rd, funct3, rs1, rs2.
    typedef struct packed {
        logic [24:0]     raw;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode of the incoming word
    // ------------------------------------------------------------------
    logic [31:0]     w_instr;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_cu;
    logic [2:0]      w_dec_fmt;
    logic [XLEN-1:0] w_dec_imm;
    logic            w_dec_illegal;
    entry_t          w_entry;

    assign w_instr  = io_bus.in_instr;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];

    // Size casts of signed operands sign-extend to XLEN.
    assign w_imm_i  = XLEN'($signed(w_instr[31:20]));
    assign w_imm_s  = XLEN'($signed({w_instr[31:25], w_instr[11:7]}));
    assign w_imm_u  = XLEN'($signed({w_instr[31:12], 12'b0}));
    assign w_imm_cu = XLEN'($signed(w_instr[31:12])) << 1;

    always_comb begin
        w_dec_fmt     = FmtIll;
        w_dec_imm     = '0;
        w_dec_illegal = 1'b1;
        case (w_opcode)
            7'b0110011: begin
                w_dec_fmt     = FmtR;
                w_dec_illegal = 1'b0;
            end
            7'b0010011, 7'b1100111: begin
                w_dec_fmt     = FmtI;
                w_dec_imm     = w_imm_i;
                w_dec_illegal = 1'b0;
            end
            7'b0000011: begin
                // Load widths 011, 110 and 111 are not defined.
                if (!(w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111)) begin
                    w_dec_fmt     = FmtI;
                    w_dec_imm     = w_imm_i;
                    w_dec_illegal = 1'b0;
                end
            end
            7'b0100011: begin
                if (w_funct3 <= 3'b010) begin
                    w_dec_fmt     = FmtS;
                    w_dec_imm     = w_imm_s;
                    w_dec_illegal = 1'b0;
                end
            end
            7'b0110111, 7'b0010111: begin
                w_dec_fmt     = FmtU;
                w_dec_imm     = w_imm_u;
                w_dec_illegal = 1'b0;
            end
            7'b1101111, 7'b1100011: begin
                w_dec_fmt     = FmtCu;
                w_dec_imm     = w_imm_cu;
                w_dec_illegal = 1'b0;
            end
            7'b1101011: begin
                w_dec_fmt     = FmtCi;
                w_dec_imm     = w_imm_i;
                w_dec_illegal = 1'b0;
            end
            7'b0000000: begin
                w_dec_fmt     = FmtNone;
                w_dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_entry.raw     = w_instr[24:0];
        w_entry.fmt     = w_dec_fmt;
        w_entry.illegal = w_dec_illegal;
        w_entry.imm     = w_dec_imm;
        w_entry.pc      = io_bus.in_pc;
    end

    // ------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------
    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    entry_t        w_head;

    assign w_nonempty       = (r_count != '0);
    assign io_bus.in_ready  = (r_count != CW'(DEPTH)) && !i_rst;
    assign io_bus.out_valid = w_nonempty;
    assign io_bus.count     = r_count;

    assign w_push = io_bus.in_valid && io_bus.in_ready;
    assign w_pop  = w_nonempty && io_bus.out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            // Any push or pop coinciding with a flush is dropped.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    assign w_head = r_mem[r_rptr];

    // ------------------------------------------------------------------
    // Head presentation, forced to zero when nothing is queued
    // ------------------------------------------------------------------
    always_comb begin
        io_bus.out_op      = '0;
        io_bus.out_fmt     = '0;
        io_bus.out_rd      = '0;
        io_bus.out_cond    = '0;
        io_bus.out_rs1     = '0;
        io_bus.out_rs2     = '0;
        io_bus.out_funct3  = '0;
        io_bus.out_imm     = '0;
        io_bus.out_pc      = '0;
        io_bus.out_illegal = 1'b0;
        if (w_nonempty) begin
            io_bus.out_op      = w_head.raw[6:0];
            io_bus.out_fmt     = w_head.fmt;
            io_bus.out_rd      = w_head.raw[11:7];
            io_bus.out_cond    = w_head.raw[11:7];
            io_bus.out_funct3  = w_head.raw[14:12];
            io_bus.out_rs1     = w_head.raw[19:15];
            io_bus.out_rs2     = w_head.raw[24:20];
            io_bus.out_imm     = w_head.imm;
            io_bus.out_pc      = w_head.pc;
            io_bus.out_illegal = w_head.illegal;
        end
    end

endmodule
